// File: rtl/inv_broadcast_queue.sv
// Invalidation broadcast queue: buffers word-address invalidations from one source and
// delivers each to NUM_SINKS sinks. Optional merging of repeated tail pushes: INV_BROADCAST_COALESCE_EN.
module inv_broadcast_queue #(
  parameter int NUM_SINKS = 2,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    src_inv_addr,
  input  logic                 src_inv_valid,
  output logic                 src_inv_ready,
  output logic                 src_inv_completed,
  output logic [4:0]           src_inv_completed_count,
  output logic [ADDR_W-1:0]    sink_inv_addr,
  output logic [NUM_SINKS-1:0] sink_inv_valid,
  input  logic [NUM_SINKS-1:0] sink_inv_ready,
  input  logic [NUM_SINKS-1:0] sink_inv_outstanding,
  output logic                 queue_empty,
  output logic                 all_idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       occ;
  logic [NUM_SINKS-1:0] acc, hs;
  logic                 full, push_wr, retire;
  logic [4:0]           done_cnt;

  assign full           = (occ == FULL_OCC);
  assign queue_empty    = (occ == '0);
  assign all_idle       = queue_empty & ~|sink_inv_outstanding;
  assign sink_inv_addr  = mem[rd_ptr];
  assign sink_inv_valid = queue_empty ? '0 : ~acc;
  assign hs             = sink_inv_valid & sink_inv_ready;
  // A sink accepting in the same cycle as the last outstanding one still counts toward retire.
  assign retire         = ~queue_empty & (&(acc | hs));

`ifdef INV_BROADCAST_COALESCE_EN
  logic [3:0]       mcnt [DEPTH];
  logic [PTR_W-1:0] tail_ptr;
  logic             tail_is_head, merge_ok, merge;

  assign tail_ptr     = wr_ptr - 1'b1;
  assign tail_is_head = (occ == (PTR_W+1)'(1));
  // Merging into the head is only safe before any sink has seen it.
  assign merge_ok     = ~queue_empty && (mem[tail_ptr] == src_inv_addr) && (mcnt[tail_ptr] != 4'd15)
                        && (~tail_is_head || ((acc | hs) == '0));
  assign merge        = src_inv_valid & merge_ok;
  assign src_inv_ready = ~full | merge_ok;
  assign push_wr      = src_inv_valid & ~full & ~merge_ok;
  assign done_cnt     = {1'b0, mcnt[rd_ptr]} + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mcnt[i] <= '0;
    end else if (push_wr) begin
      mcnt[wr_ptr] <= '0;
    end else if (merge) begin
      mcnt[tail_ptr] <= mcnt[tail_ptr] + 4'd1;
    end
  end
`else
  assign src_inv_ready = ~full;
  assign push_wr       = src_inv_valid & ~full;
  assign done_cnt      = 5'd1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset so the shared sink address reads 0 out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      occ                     <= '0;
      acc                     <= '0;
      src_inv_completed       <= 1'b0;
      src_inv_completed_count <= '0;
    end else begin
      if (push_wr) begin
        mem[wr_ptr] <= src_inv_addr;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (retire) begin
        rd_ptr <= rd_ptr + 1'b1;
        acc    <= '0;
      end else begin
        acc <= acc | hs;
      end
      case ({push_wr, retire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      src_inv_completed       <= retire;
      src_inv_completed_count <= retire ? done_cnt : 5'd0;
    end
  end

endmodule

// File: tb/tb_inv_broadcast_queue.sv
// Scoreboard bench for inv_broadcast_queue: stimulus queues expected sink addresses and
// completion counts; a negedge monitor pops and compares as the DUT presents them.
module tb_inv_broadcast_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] src_inv_addr = '0;
  logic        src_inv_valid = 1'b0;
  logic        src_inv_ready;
  logic        src_inv_completed;
  logic [4:0]  src_inv_completed_count;
  logic [29:0] sink_inv_addr;
  logic [1:0]  sink_inv_valid;
  logic [1:0]  sink_inv_ready = 2'b00;
  logic [1:0]  sink_inv_outstanding = 2'b00;
  logic        queue_empty;
  logic        all_idle;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;
  int snap;

  logic [29:0] exp_a0[$];
  logic [29:0] exp_a1[$];
  logic [4:0]  exp_cnt[$];

  inv_broadcast_queue #(.NUM_SINKS(2), .DEPTH(4), .ADDR_W(30)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .src_inv_addr            (src_inv_addr),
    .src_inv_valid           (src_inv_valid),
    .src_inv_ready           (src_inv_ready),
    .src_inv_completed       (src_inv_completed),
    .src_inv_completed_count (src_inv_completed_count),
    .sink_inv_addr           (sink_inv_addr),
    .sink_inv_valid          (sink_inv_valid),
    .sink_inv_ready          (sink_inv_ready),
    .sink_inv_outstanding    (sink_inv_outstanding),
    .queue_empty             (queue_empty),
    .all_idle                (all_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [29:0] a, input logic [4:0] c);
    exp_a0.push_back(a);
    exp_a1.push_back(a);
    exp_cnt.push_back(c);
  endtask

  // Holds src_inv_valid until accepted; returns at 1 time unit after the accepting edge.
  task automatic push(input logic [29:0] a, input bit exp_en);
    bit accepted = 1'b0;
    int n = 0;
    src_inv_addr  = a;
    src_inv_valid = 1'b1;
    while (!accepted && n < 40) begin
      @(negedge clk);
      accepted = src_inv_ready;
      step();
      n++;
    end
    src_inv_valid = 1'b0;
    check("push_accepted", 32'(accepted), 32'd1);
    if (accepted && exp_en) expect_entry(a, 5'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (!queue_empty && n < 100) begin
      step();
      n++;
    end
    check("drain_empty", 32'(queue_empty), 32'd1);
    step();
    step();
  endtask

  // Monitor: every sink handshake and completion pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (sink_inv_valid[0] && sink_inv_ready[0]) begin
        if (exp_a0.size() == 0) check("sink0_unexpected", 32'(exp_a0.size()), 32'd1);
        else check("sink0_addr", 32'(sink_inv_addr), 32'(exp_a0.pop_front()));
      end
      if (sink_inv_valid[1] && sink_inv_ready[1]) begin
        if (exp_a1.size() == 0) check("sink1_unexpected", 32'(exp_a1.size()), 32'd1);
        else check("sink1_addr", 32'(sink_inv_addr), 32'(exp_a1.pop_front()));
      end
      if (src_inv_completed) begin
        n_pulse++;
        if (exp_cnt.size() == 0) check("pulse_unexpected", 32'(exp_cnt.size()), 32'd1);
        else check("completed_count", 32'(src_inv_completed_count), 32'(exp_cnt.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check("rst_queue_empty", 32'(queue_empty), 32'd1);
    check("rst_src_ready", 32'(src_inv_ready), 32'd1);
    check("rst_sink_valid", 32'(sink_inv_valid), 32'd0);
    check("rst_sink_addr", 32'(sink_inv_addr), 32'd0);
    check("rst_completed", 32'(src_inv_completed), 32'd0);
    check("rst_completed_count", 32'(src_inv_completed_count), 32'd0);
    check("rst_all_idle", 32'(all_idle), 32'd1);
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single request, both sinks ready
    sink_inv_ready = 2'b11;
    push(30'h0000100, 1'b1);
    check("t1_sink_valid", 32'(sink_inv_valid), 32'h3);
    check("t1_sink_addr", 32'(sink_inv_addr), 32'h100);
    step();
    check("t1_completed", 32'(src_inv_completed), 32'd1);
    check("t1_count", 32'(src_inv_completed_count), 32'd1);
    check("t1_queue_empty", 32'(queue_empty), 32'd1);
    step();
    check("t1_completed_drop", 32'(src_inv_completed), 32'd0);
    sink_inv_outstanding = 2'b01;
    #1 check("t1_all_idle_busy", 32'(all_idle), 32'd0);
    sink_inv_outstanding = 2'b00;
    #1 check("t1_all_idle", 32'(all_idle), 32'd1);

    // Staggered accept: sink0 first, sink1 three cycles later
    sink_inv_ready = 2'b00;
    push(30'h0000200, 1'b1);
    check("t2_sink_valid_both", 32'(sink_inv_valid), 32'h3);
    sink_inv_ready = 2'b01;
    step();
    sink_inv_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      check("t2_sink_valid_hold", 32'(sink_inv_valid), 32'h2);
      check("t2_addr_hold", 32'(sink_inv_addr), 32'h200);
      check("t2_no_pulse", 32'(src_inv_completed), 32'd0);
      if (i < 2) step();
    end
    snap = n_pulse;
    sink_inv_ready = 2'b10;
    step();
    check("t2_empty_after_retire", 32'(queue_empty), 32'd1);
    step();
    step();
    check("t2_single_pulse", 32'(n_pulse - snap), 32'd1);

    // Fill, then wrap the pointers with six more entries
    sink_inv_ready = 2'b00;
    snap = n_pulse;
    for (int i = 0; i < 4; i++) push(30'h1000 + 30'(i), 1'b1);
    check("t3_full_not_ready", 32'(src_inv_ready), 32'd0);
    check("t3_not_empty", 32'(queue_empty), 32'd0);
    sink_inv_ready = 2'b11;
    for (int i = 4; i < 10; i++) push(30'h1000 + 30'(i), 1'b1);
    drain();
    check("t3_ten_pulses", 32'(n_pulse - snap), 32'd10);

    // Full plus retire with a pending push: no bypass
    sink_inv_ready = 2'b00;
    for (int i = 0; i < 4; i++) push(30'h2000 + 30'(i), 1'b1);
    src_inv_addr   = 30'h2555;
    src_inv_valid  = 1'b1;
    sink_inv_ready = 2'b11;
    @(negedge clk);
    check("t4_ready_while_full", 32'(src_inv_ready), 32'd0);
    step();
    check("t4_ready_after_retire", 32'(src_inv_ready), 32'd1);
    expect_entry(30'h2555, 5'd1);
    step();
    src_inv_valid = 1'b0;
    drain();

    // Asynchronous reset mid-broadcast
    sink_inv_ready = 2'b00;
    for (int i = 0; i < 3; i++) push(30'h3000 + 30'(i), 1'b1);
    sink_inv_ready = 2'b01;
    step();
    sink_inv_ready = 2'b00;
    check("t5_acc_01", 32'(sink_inv_valid), 32'h2);
    snap = n_pulse;
    #2 rst = 1'b1;
    #1;
    check("t5_queue_empty", 32'(queue_empty), 32'd1);
    check("t5_src_ready", 32'(src_inv_ready), 32'd1);
    check("t5_sink_valid", 32'(sink_inv_valid), 32'd0);
    check("t5_sink_addr", 32'(sink_inv_addr), 32'd0);
    check("t5_completed", 32'(src_inv_completed), 32'd0);
    check("t5_count", 32'(src_inv_completed_count), 32'd0);
    exp_a0.delete();
    exp_a1.delete();
    exp_cnt.delete();
    step();
    step();
    rst = 1'b0;
    step();
    step();
    check("t5_no_pulse", 32'(n_pulse - snap), 32'd0);
    check("t5_still_empty", 32'(queue_empty), 32'd1);

    // Repeated address while sinks are stalled
    sink_inv_ready = 2'b00;
    snap = n_pulse;
`ifdef INV_BROADCAST_COALESCE_EN
    for (int i = 0; i < 3; i++) push(30'h40, 1'b0);
    expect_entry(30'h40, 5'd3);
    check("t6_ready_after_merge", 32'(src_inv_ready), 32'd1);
    sink_inv_ready = 2'b11;
    drain();
    check("t6_pulses", 32'(n_pulse - snap), 32'd1);
`else
    for (int i = 0; i < 3; i++) push(30'h40, 1'b1);
    check("t6_ready_three_held", 32'(src_inv_ready), 32'd1);
    sink_inv_ready = 2'b11;
    drain();
    check("t6_pulses", 32'(n_pulse - snap), 32'd3);
`endif

    check("end_sink0_drained", 32'(exp_a0.size()), 32'd0);
    check("end_sink1_drained", 32'(exp_a1.size()), 32'd0);
    check("end_counts_drained", 32'(exp_cnt.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inv_broadcast_queue.md
Name: inv_broadcast_queue

Overview:
- Parametrised successor to the single-sink instruction invalidation path: buffers word-addressed invalidations from one source and broadcasts each to NUM_SINKS sinks (I-caches, fetch buffers, trace caches).
- An entry retires only when every sink has accepted it.
- Reports completions back to the source and exposes global idle status for fence.i handling.

Parameters:
- NUM_SINKS, 2, number of invalidation sinks (1..8)
- DEPTH, 4, queue entries; power of two, >=2
- ADDR_W, 30, word address width (bits [31:2])

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- src_inv_addr  in  ADDR_W  word address to invalidate
- src_inv_valid  in  1  source request
- src_inv_ready  out  1  queue can accept this cycle
- src_inv_completed  out  1  one-cycle pulse: head entry delivered to all sinks
- src_inv_completed_count  out  5  number of source requests retired by that pulse
- sink_inv_addr  out  ADDR_W  head entry address, shared by all sinks
- sink_inv_valid  out  NUM_SINKS  per-sink request
- sink_inv_ready  in  NUM_SINKS  per-sink accept
- sink_inv_outstanding  in  NUM_SINKS  sink still processing an accepted invalidation
- queue_empty  out  1  no entries held
- all_idle  out  1  queue_empty and no sink_inv_outstanding bit set

Behaviour:
- Storage: circular FIFO with DEPTH entries. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- src_inv_ready = ~full, from registered state only. No bypass: a pop in the same cycle does not free a slot while full.
- Push on src_inv_valid & src_inv_ready.
- Latency: a pushed entry into an empty queue appears on the sinks the next cycle.
- Per-sink accepted mask acc[NUM_SINKS], registered.
  - sink_inv_valid[i] = ~queue_empty & ~acc[i].
  - A handshake on sink i (valid & ready) sets acc[i].
- Retire when (acc | handshakes this cycle) is all ones. On retire:
  - pop the head;
  - clear acc to 0;
  - next cycle, pulse src_inv_completed with src_inv_completed_count = entry merge count + 1.
- Sinks may accept in any order and in different cycles. sink_inv_addr holds stable until retire.
- Simultaneous push and retire while not full: occupancy unchanged, both pointers advance.
- all_idle is combinational from the registered occupancy and sink_inv_outstanding.
- Reset values:
  - pointers and occupancy 0, acc 0;
  - src_inv_completed 0, src_inv_completed_count 0;
  - queue_empty 1, src_inv_ready 1;
  - sink_inv_valid all 0;
  - sink_inv_addr 0, since entry storage is reset.
- Reset mid-broadcast discards all entries. No completion pulse is issued for discarded entries.

Optional Feature:
- Macro: INV_BROADCAST_COALESCE_EN.
- With the macro:
  - A push whose address equals the tail entry (most recently written, still queued) is merged when that entry has acc == 0 (or is not the head) and its 4-bit merge count is < 15.
  - A merge increments the entry's merge count and writes nothing. src_inv_ready stays high for merges even when full.
  - Completion count = merges + 1.
- Without the macro: no comparator and no merge-count storage; every push writes an entry and src_inv_completed_count is always 1.

Test Plan:
- Single request, NUM_SINKS=2, both sinks ready: push 0x0000100 -> sink_inv_valid=2'b11 next cycle, retire the same cycle, src_inv_completed=1 with count=1 one cycle later, then queue_empty=1.
- Staggered accept: sink0 ready at cycle 1, sink1 ready at cycle 4 -> sink_inv_valid=2'b10 during cycles 2-4, a single completion pulse after cycle 4, address held throughout.
- Fill/wrap: sinks stalled, push 4 entries -> src_inv_ready=0. Release sinks and push 6 more -> all 10 delivered in order across pointer wrap, 10 completion pulses.
- Full plus retire in the same cycle with src_inv_valid high -> no push that cycle, push accepted the next cycle.
- Reset asserted with 3 entries and acc=2'b01 -> all outputs at reset values immediately (async), no completion pulse.
- With INV_BROADCAST_COALESCE_EN: sinks stalled, push 0x40 three times -> one entry, occupancy 1. Release sinks -> one pulse with count=3. Without the macro -> three pulses, each with count=1.
